// File: rtl/alu_stack_sequencer.sv
// Operand sequencer for the 8-bit ALU: a small working stack feeding op1/op2,
// with literal pushes, result writeback and sticky error reporting.
module alu_stack_sequencer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_push,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  output logic [7:0]       alu_op1,
  output logic [7:0]       alu_op2,
  output logic [3:0]       alu_operation,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic [7:0]       top,
  output logic [CNT_W-1:0] count,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_illegal
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  logic [7:0]       stack_mem [DEPTH];
  logic [1:0]       state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [7:0]       top_reg;
  logic [3:0]       op_reg;
  logic [7:0]       op1_reg, op2_reg;
  logic [3:0]       operation_reg;
  logic [7:0]       result_reg;
  logic             carry_cap_reg, zero_cap_reg;
  logic             carry_flag_reg, zero_flag_reg;
  logic             done_reg;
  logic             ovf_reg, unf_reg, ill_reg;

  logic             accept;
  logic             full;
  logic [AW-1:0]    second_ptr;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [7:0]       mem_wdata;

  assign cmd_ready  = rst_n && (state_reg == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign second_ptr = AW'(count_reg - CNT_W'(2));

  // One write port shared by literal pushes and ALU writeback; both are
  // suppressed while reset is asserted so an abandoned op leaves no trace.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = AW'(count_reg);
    mem_wdata = cmd_data;
    if (rst_n) begin
      if (accept && cmd_push && !full) begin
        mem_we = 1'b1;
      end else if (state_reg == ST_WB) begin
        mem_we    = 1'b1;
        mem_waddr = second_ptr;
        mem_wdata = result_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      stack_mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      top_reg        <= '0;
      op_reg         <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      operation_reg  <= '0;
      result_reg     <= '0;
      carry_cap_reg  <= 1'b0;
      zero_cap_reg   <= 1'b0;
      carry_flag_reg <= 1'b0;
      zero_flag_reg  <= 1'b0;
      done_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      unf_reg        <= 1'b0;
      ill_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_push) begin
              done_reg <= 1'b1;
              if (full) begin
                ovf_reg <= 1'b1;
              end else begin
                count_reg <= count_reg + CNT_W'(1);
                top_reg   <= cmd_data;
              end
            end else if (cmd_op[3]) begin
              ill_reg  <= 1'b1;
              done_reg <= 1'b1;
            end else if (count_reg < CNT_W'(2)) begin
              unf_reg  <= 1'b1;
              done_reg <= 1'b1;
            end else begin
              op_reg    <= cmd_op;
              state_reg <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // top_reg mirrors stack[count-1], so only one array read is needed
          op1_reg       <= stack_mem[second_ptr];
          op2_reg       <= top_reg;
          operation_reg <= op_reg;
          state_reg     <= ST_EXEC;
        end
        ST_EXEC: begin
          result_reg    <= alu_result;
          carry_cap_reg <= alu_carry;
          zero_cap_reg  <= alu_zero;
          state_reg     <= ST_WB;
        end
        default: begin
          count_reg      <= count_reg - CNT_W'(1);
          top_reg        <= result_reg;
          carry_flag_reg <= carry_cap_reg;
          zero_flag_reg  <= zero_cap_reg;
          done_reg       <= 1'b1;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_op1       = op1_reg;
  assign alu_op2       = op2_reg;
  assign alu_operation = operation_reg;
  assign done          = done_reg;
  assign carry_flag    = carry_flag_reg;
  assign zero_flag     = zero_flag_reg;
  assign top           = top_reg;
  assign count         = count_reg;
  assign err_overflow  = ovf_reg;
  assign err_underflow = unf_reg;
  assign err_illegal   = ill_reg;

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Bench for alu_stack_sequencer: combinational ALU stand-in, queue-based stack
// model, directed scenarios followed by randomized command streams.
module tb_alu_stack_sequencer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_push;
  logic [3:0]       cmd_op;
  logic [7:0]       cmd_data;
  logic [7:0]       alu_op1, alu_op2;
  logic [3:0]       alu_operation;
  logic [7:0]       alu_result;
  logic             alu_carry, alu_zero;
  logic             done, carry_flag, zero_flag;
  logic [7:0]       top;
  logic [CNT_W-1:0] count;
  logic             err_overflow, err_underflow, err_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_stack_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_push(cmd_push), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .done(done), .carry_flag(carry_flag), .zero_flag(zero_flag), .top(top),
    .count(count), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_illegal(err_illegal)
  );

  // {carry, result}; SUB carry is borrow, MUL carry is a non-zero high byte,
  // divide by zero yields 0, SFT is right by b[3:0] then left by b[7:4].
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [15:0] w;
    case (op)
      4'd0: begin w = 16'(a) + 16'(b); return {w[8], w[7:0]}; end
      4'd1: return {a < b, a - b};
      4'd2: begin w = 16'(a) * 16'(b); return {|w[15:8], w[7:0]}; end
      4'd3: return {1'b0, (b == 8'd0) ? 8'd0 : a / b};
      4'd4: return {1'b0, a & b};
      4'd5: return {1'b0, a | b};
      4'd6: return {1'b0, a ^ b};
      4'd7: begin w = (16'(a) >> b[3:0]) << b[7:4]; return {1'b0, w[7:0]}; end
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] alu_out;
  assign alu_out    = alu_fn(alu_op1, alu_op2, alu_operation);
  assign alu_result = alu_out[7:0];
  assign alu_carry  = alu_out[8];
  assign alu_zero   = (alu_out[7:0] == 8'd0);

  // Reference model: the stack as a byte queue, back = top.
  logic [7:0] model_q[$];
  bit m_ovf, m_unf, m_ill, m_carry, m_zero;

  task automatic model_clear();
    model_q.delete();
    m_ovf = 0; m_unf = 0; m_ill = 0; m_carry = 0; m_zero = 0;
  endtask

  task automatic model_step(input bit push, input logic [3:0] op, input logic [7:0] data,
                            output int exp_lat, output logic [7:0] ea, output logic [7:0] eb);
    logic [8:0] r;
    ea = 8'd0; eb = 8'd0; exp_lat = 1;
    if (push) begin
      if (model_q.size() == DEPTH) m_ovf = 1;
      else model_q.push_back(data);
    end else if (op >= 4'd8) begin
      m_ill = 1;
    end else if (model_q.size() < 2) begin
      m_unf = 1;
    end else begin
      eb = model_q.pop_back();
      ea = model_q.pop_back();
      r = alu_fn(ea, eb, op);
      model_q.push_back(r[7:0]);
      m_carry = r[8];
      m_zero  = (r[7:0] == 8'd0);
      exp_lat = 4;
    end
  endtask

  // Issues one command and waits (bounded) for done; lat is cycles from the
  // accept edge to the done cycle, -1 on timeout. EXEC-cycle ALU inputs are
  // captured from the second cycle after accept.
  task automatic issue(input bit push, input logic [3:0] op, input logic [7:0] data,
                       output int lat, output logic [7:0] x_op1, output logic [7:0] x_op2,
                       output logic [3:0] x_opr);
    int w;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b1; cmd_push = push; cmd_op = op; cmd_data = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_data = 8'($urandom);
    lat = 0; x_op1 = 8'd0; x_op2 = 8'd0; x_opr = 4'd0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        x_op1 = alu_op1; x_op2 = alu_op2; x_opr = alu_operation;
      end
    end while (!done && lat < 20);
    if (!done) lat = -1;
    $display("  txn push=%0d op=%0d data=%02h lat=%0d count=%0d top=%02h c=%0b z=%0b err=%0b%0b%0b",
             push, op, data, lat, count, top, carry_flag, zero_flag,
             err_overflow, err_underflow, err_illegal);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (top !== 8'h00) begin errors++; $display("FAIL reset_top: got %02h want 00", top); end
    checks++; if ({carry_flag, zero_flag, err_overflow, err_underflow, err_illegal} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %05b want 00000",
                         {carry_flag, zero_flag, err_overflow, err_underflow, err_illegal}); end
    checks++; if ({alu_op1, alu_op2, alu_operation} !== 20'h0) begin
      errors++; $display("FAIL reset_alu_in: got %05h want 00000", {alu_op1, alu_op2, alu_operation}); end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_sub();
    int lat; logic [7:0] a, b; logic [3:0] o;
    do_reset();
    issue(1, 4'd0, 8'h05, lat, a, b, o);
    checks++; if (lat != 1) begin errors++; $display("FAIL sub_push_lat: got %0d want 1", lat); end
    issue(1, 4'd0, 8'h03, lat, a, b, o);
    issue(0, 4'd1, 8'h00, lat, a, b, o);
    checks++; if (lat != 4) begin errors++; $display("FAIL sub_lat: got %0d want 4", lat); end
    checks++; if (top !== 8'h02) begin errors++; $display("FAIL sub_top: got %02h want 02", top); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL sub_count: got %0d want 1", count); end
    checks++; if ({carry_flag, zero_flag} !== 2'b00) begin errors++; $display("FAIL sub_flags: got %b%b want 00", carry_flag, zero_flag); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL sub_ready_at_done: got %b want 1", cmd_ready); end
  endtask

  task automatic test_add_carry();
    int lat; logic [7:0] a, b; logic [3:0] o;
    do_reset();
    issue(1, 4'd0, 8'hF0, lat, a, b, o);
    issue(1, 4'd0, 8'h20, lat, a, b, o);
    issue(0, 4'd0, 8'h00, lat, a, b, o);
    checks++; if ({a, b, o} !== {8'hF0, 8'h20, 4'd0}) begin
      errors++; $display("FAIL add_exec_inputs: got %02h %02h %0d want f0 20 0", a, b, o); end
    checks++; if (top !== 8'h10) begin errors++; $display("FAIL add_top: got %02h want 10", top); end
    checks++; if ({carry_flag, zero_flag} !== 2'b10) begin errors++; $display("FAIL add_flags: got %b%b want 10", carry_flag, zero_flag); end
    // a push must leave the flags alone
    issue(1, 4'd0, 8'h00, lat, a, b, o);
    checks++; if ({carry_flag, zero_flag} !== 2'b10) begin errors++; $display("FAIL add_flags_after_push: got %b%b want 10", carry_flag, zero_flag); end
  endtask

  task automatic test_div_zero();
    int lat; logic [7:0] a, b; logic [3:0] o;
    do_reset();
    issue(1, 4'd0, 8'h07, lat, a, b, o);
    issue(1, 4'd0, 8'h00, lat, a, b, o);
    issue(0, 4'd3, 8'h00, lat, a, b, o);
    checks++; if (top !== 8'h00) begin errors++; $display("FAIL div_top: got %02h want 00", top); end
    checks++; if (zero_flag !== 1'b1) begin errors++; $display("FAIL div_zero_flag: got %b want 1", zero_flag); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL div_count: got %0d want 1", count); end
    checks++; if ({err_overflow, err_underflow, err_illegal} !== 3'b000) begin
      errors++; $display("FAIL div_errors: got %b%b%b want 000", err_overflow, err_underflow, err_illegal); end
  endtask

  task automatic test_underflow();
    int lat; logic [7:0] a, b; logic [3:0] o;
    do_reset();
    issue(0, 4'd4, 8'h00, lat, a, b, o);
    checks++; if (lat != 1) begin errors++; $display("FAIL unf_lat: got %0d want 1", lat); end
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b want 1", err_underflow); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL unf_count: got %0d want 0", count); end
    issue(1, 4'd0, 8'h11, lat, a, b, o);
    issue(0, 4'd5, 8'h00, lat, a, b, o);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky: got %b want 1", err_underflow); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL unf_count2: got %0d want 1", count); end
    checks++; if (top !== 8'h11) begin errors++; $display("FAIL unf_top: got %02h want 11", top); end
  endtask

  task automatic test_overflow();
    int lat; logic [7:0] a, b; logic [3:0] o;
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(1, 4'd0, 8'(i), lat, a, b, o);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_full_count: got %0d want 16", count); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
    issue(1, 4'd0, 8'hAA, lat, a, b, o);
    checks++; if (lat != 1) begin errors++; $display("FAIL ovf_lat: got %0d want 1", lat); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
    checks++; if ({count, top} !== {5'd16, 8'h0F}) begin errors++; $display("FAIL ovf_state: got %0d/%02h want 16/0f", count, top); end
    issue(0, 4'd6, 8'h00, lat, a, b, o);
    checks++; if ({count, top} !== {5'd15, 8'h01}) begin errors++; $display("FAIL ovf_xor: got %0d/%02h want 15/01", count, top); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_push = 1'b1; cmd_data = 8'h40 + 8'(i);
      @(negedge clk);
      checks++; if ({done, cmd_ready} !== 2'b11) begin
        errors++; $display("FAIL b2b_done_ready[%0d]: got %b%b want 11", i, done, cmd_ready); end
    end
    cmd_valid = 1'b0;
    checks++; if ({count, top} !== {5'd8, 8'h47}) begin errors++; $display("FAIL b2b_state: got %0d/%02h want 8/47", count, top); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_end: got %b want 0", done); end
  endtask

  task automatic test_illegal_reset();
    int lat; logic [7:0] a, b; logic [3:0] o;
    do_reset();
    issue(1, 4'd0, 8'h01, lat, a, b, o);
    issue(1, 4'd0, 8'h02, lat, a, b, o);
    issue(0, 4'd9, 8'h00, lat, a, b, o);
    checks++; if (lat != 1) begin errors++; $display("FAIL ill_lat: got %0d want 1", lat); end
    checks++; if ({err_illegal, count} !== {1'b1, 5'd2}) begin errors++; $display("FAIL ill_state: got %b/%0d want 1/2", err_illegal, count); end
    // MUL with reset landing in EXEC
    @(negedge clk);
    cmd_valid = 1'b1; cmd_push = 1'b0; cmd_op = 4'd2;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({count, done} !== {5'd0, 1'b0}) begin errors++; $display("FAIL midrst_state: got %0d/%b want 0/0", count, done); end
    checks++; if ({err_overflow, err_underflow, err_illegal} !== 3'b000) begin
      errors++; $display("FAIL midrst_errors: got %b%b%b want 000", err_overflow, err_underflow, err_illegal); end
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({done, cmd_ready, count} !== {1'b0, 1'b1, 5'd0}) begin
        errors++; $display("FAIL midrst_after[%0d]: got done=%b ready=%b count=%0d want 0 1 0", i, done, cmd_ready, count); end
    end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [7:0] a, b, ea, eb; logic [3:0] o, op; bit push; logic [7:0] data;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      push = ($urandom_range(0, 99) < 55);
      op   = 4'($urandom_range(0, 9));
      data = 8'($urandom);
      model_step(push, op, data, exp_lat, ea, eb);
      issue(push, op, data, lat, a, b, o);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, lat, exp_lat); end
      checks++; if (count !== CNT_W'(model_q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, count, model_q.size()); end
      checks++; if (top !== ((model_q.size() == 0) ? 8'h00 : model_q[$])) begin
        errors++; $display("FAIL rnd_top[%0d]: got %02h want %02h", n, top, (model_q.size() == 0) ? 8'h00 : model_q[$]); end
      checks++; if ({carry_flag, zero_flag, err_overflow, err_underflow, err_illegal} !== {m_carry, m_zero, m_ovf, m_unf, m_ill}) begin
        errors++; $display("FAIL rnd_flags[%0d]: got %05b want %05b", n,
                           {carry_flag, zero_flag, err_overflow, err_underflow, err_illegal},
                           {m_carry, m_zero, m_ovf, m_unf, m_ill}); end
      if (exp_lat == 4) begin
        checks++; if ({a, b, o} !== {ea, eb, op}) begin
          errors++; $display("FAIL rnd_exec_inputs[%0d]: got %02h %02h %0d want %02h %02h %0d", n, a, b, o, ea, eb, op); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rnd_done_pulse[%0d]: got %b want 0", n, done); end
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_push = 1'b0; cmd_op = 4'd0; cmd_data = 8'd0;
    model_clear();
    test_reset();
    test_sub();
    test_add_carry();
    test_div_zero();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_illegal_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_stack_sequencer.md
Name: alu_stack_sequencer

Overview:
- Operand-side driver for the 8-bit ALU: owns a small working stack, pops two operands, drives the ALU's op1/op2/operation inputs, captures result/carry/zero, pushes result back.
- Sits between instruction decode (command valid/ready) and the combinational ALU; uxn-style stack semantics (a b OP -> r, b = top).
- Also accepts literal pushes. Reports sticky errors for overflow, underflow and illegal opcode.

Parameters:
- DEPTH, 16, stack entries; power of two, 4..256.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (holds 0..DEPTH).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept command
- cmd_push  in  1  1 = push cmd_data literal, 0 = ALU op cmd_op
- cmd_op  in  4  ALU op code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 SFT; 8-15 illegal
- cmd_data  in  8  literal for push
- alu_op1  out  8  to ALU op1 (second-from-top, "a")
- alu_op2  out  8  to ALU op2 (top, "b")
- alu_operation  out  4  to ALU operation
- alu_result  in  8  from ALU
- alu_carry  in  1  from ALU carry_out
- alu_zero  in  1  from ALU zero_out
- done  out  1  one-cycle pulse, command completed (incl. errored)
- carry_flag  out  1  carry latched at last ALU writeback
- zero_flag  out  1  zero latched at last ALU writeback
- top  out  8  stack[count-1]; 0 when empty
- count  out  CNT_W  current occupancy
- err_overflow  out  1  sticky
- err_underflow  out  1  sticky
- err_illegal  out  1  sticky

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, count=0, done=0, all flags/errors=0, alu_op1/op2/operation=0. Stack array not reset. cmd_ready=0 while rst_n=0; 1 in first cycle after release.
- Reset mid-operation: command abandoned, no writeback, no done.
- cmd_ready = (state==IDLE). Handshake = cmd_valid & cmd_ready at rising edge; command fields sampled only then.
- FSM: IDLE, FETCH, EXEC, WB.
- Push (cmd_push=1), accepted in IDLE:
  - count<DEPTH: stack[count]=cmd_data, count+1.
  - count==DEPTH: no write, err_overflow=1.
  - Either case: done=1 next cycle, stay IDLE. Back-to-back pushes sustain 1 per cycle.
- ALU op (cmd_push=0), accepted in IDLE:
  - cmd_op>=8: err_illegal=1, done pulse, stack unchanged, stay IDLE.
  - count<2: err_underflow=1, done pulse, stack unchanged, stay IDLE.
  - Otherwise -> FETCH.
- FETCH:
  - alu_op1 <= stack[count-2], alu_op2 <= stack[count-1], alu_operation <= cmd_op (registered).
  - -> EXEC.
- EXEC: ALU inputs stable a full cycle; at edge capture alu_result/alu_carry/alu_zero into internal regs. -> WB.
- WB:
  - At edge: stack[count-2] = captured result, count-1, carry_flag/zero_flag updated, done=1 next cycle. -> IDLE.
- Latency: accept edge E0, done high in cycle after E3. cmd_ready high in that same cycle; next op accepted at E4.
- carry_flag/zero_flag change only on successful ALU writeback. Errored or push commands leave them untouched.
- alu_op1/op2/operation hold their last values outside FETCH..WB.
- Errors sticky until reset; never block further commands.
- Count arithmetic never wraps: guarded by the full/underflow checks above.

Test Plan:
- Reset, then push 0x05, push 0x03, op SUB(1) -> done 3 cycles after the accept-cycle done slot; top=0x02, count=1, zero_flag=0, carry_flag=0.
- Push 0xF0, push 0x20, op ADD(0) -> top=0x10, carry_flag=1, zero_flag=0; alu_op1=0xF0, alu_op2=0x20 during EXEC.
- Push 0x07, push 0x00, op DIV(3) -> top=0x00, zero_flag=1, count=1, no error.
- Empty stack, op AND(4) -> err_underflow=1, done pulse next cycle, count=0. Then push 0x11, op OR -> err_underflow stays 1, count=1, top=0x11.
- DEPTH pushes of 0x00..0x0F, 17th push 0xAA -> err_overflow=1, count=16, top=0x0F. Then op XOR(6) -> top=0x0E^0x0F=0x01, count=15.
- Push 0x01, push 0x02, op 0x9 -> err_illegal=1, count=2. Then op MUL, with rst_n=0 asserted in EXEC -> next cycle count=0, no done, all errors 0, cmd_ready=1 after release.
